// File: rtl/series2parallel_if.sv
// Handshake and data bundle for the 8-lane serial-to-parallel deserializer.
// The slave side is the deserializer; the master side drives samples and consumes blocks.
interface series2parallel_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  I_en;
  logic                  I_data_valid;
  logic [DATA_WIDTH-1:0] I_d;
  logic                  O_ready;
  logic                  I_flush;
  logic                  I_pop;
  logic [DATA_WIDTH-1:0] O_q0, O_q1, O_q2, O_q3, O_q4, O_q5, O_q6, O_q7;
  logic                  O_data_valid;
  logic [2:0]            O_level;

  modport slave (
    input  I_en, I_data_valid, I_d, I_flush, I_pop,
    output O_ready, O_q0, O_q1, O_q2, O_q3, O_q4, O_q5, O_q6, O_q7,
           O_data_valid, O_level
  );

  modport master (
    output I_en, I_data_valid, I_d, I_flush, I_pop,
    input  O_ready, O_q0, O_q1, O_q2, O_q3, O_q4, O_q5, O_q6, O_q7,
           O_data_valid, O_level
  );
endinterface

// File: rtl/series2parallel.sv
// Collects 8 serial samples into one parallel block with a single holding slot.
// A second block may fill while the slot waits; a complete second block stalls input.
module series2parallel #(
  parameter int DATA_WIDTH = 16
) (
  input logic               I_clk,
  input logic               I_rst,
  series2parallel_if.slave  bus
);
  typedef enum logic {FILL, FULL_WAIT} state_t;

  state_t                       state;
  logic [7:0][DATA_WIDTH-1:0]   fill, fill_acc, q;
  logic [2:0]                   cnt;
  logic [3:0]                   cnt_acc;
  logic                         dv;
  logic                         accept, complete, slot_free;

  // fill_acc/cnt_acc include this cycle's sample so flush and completion see it.
  always_comb begin
    accept   = bus.I_en & bus.I_data_valid & (state == FILL);
    fill_acc = fill;
    if (accept) fill_acc[cnt] = bus.I_d;
    cnt_acc  = {1'b0, cnt} + {3'b0, accept};
    complete = (state == FILL) & bus.I_en &
               ((accept & (cnt == 3'd7)) | (bus.I_flush & (cnt_acc != 4'd0)));
    slot_free = ~dv | (bus.I_en & bus.I_pop);
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= FILL;
      fill  <= '0;
      cnt   <= '0;
      q     <= '0;
      dv    <= 1'b0;
    end else if (bus.I_en) begin
      case (state)
        FILL: begin
          if (complete) begin
            cnt <= '0;
            if (slot_free) begin
              q    <= fill_acc;
              dv   <= 1'b1;
              fill <= '0;
            end else begin
              // Held block stays in the fill buffer until the slot is popped.
              fill  <= fill_acc;
              state <= FULL_WAIT;
            end
          end else begin
            fill <= fill_acc;
            cnt  <= cnt_acc[2:0];
            if (bus.I_pop) dv <= 1'b0;
          end
        end
        FULL_WAIT: begin
          if (bus.I_pop) begin
            q     <= fill;
            dv    <= 1'b1;
            fill  <= '0;
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.O_ready      = (state == FILL);
  assign bus.O_data_valid = dv;
  assign bus.O_level      = cnt;
  assign bus.O_q0 = q[0];
  assign bus.O_q1 = q[1];
  assign bus.O_q2 = q[2];
  assign bus.O_q3 = q[3];
  assign bus.O_q4 = q[4];
  assign bus.O_q5 = q[5];
  assign bus.O_q6 = q[6];
  assign bus.O_q7 = q[7];
endmodule

// File: tb/tb_series2parallel.sv
// Directed and random stimulus for series2parallel against a queue-based block model.
module tb_series2parallel;
  logic I_clk = 1'b0;
  logic I_rst;
  int   n_chk = 0;
  int   n_err = 0;

  series2parallel_if #(.DATA_WIDTH(16)) bus ();

  series2parallel #(.DATA_WIDTH(16)) dut (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .bus   (bus.slave)
  );

  always #5 I_clk = ~I_clk;

  // Reference model: pending samples, one waiting block, one output slot
  logic [15:0]         fillq[$];
  bit                  held;
  logic [7:0][15:0]    heldblk, slot;
  bit                  sval;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] dut_q();
    return {bus.O_q7, bus.O_q6, bus.O_q5, bus.O_q4,
            bus.O_q3, bus.O_q2, bus.O_q1, bus.O_q0};
  endfunction

  task automatic model_edge();
    logic [7:0][15:0] blk;
    if (I_rst) begin
      fillq.delete();
      held = 0; sval = 0; slot = '0; heldblk = '0;
    end else if (bus.I_en) begin
      if (held) begin
        if (bus.I_pop) begin
          slot = heldblk; sval = 1; held = 0;
        end
      end else begin
        if (bus.I_data_valid) fillq.push_back(bus.I_d);
        if (fillq.size() == 8 || (bus.I_flush && fillq.size() > 0)) begin
          blk = '0;
          foreach (fillq[i]) blk[i] = fillq[i];
          fillq.delete();
          if (!sval || bus.I_pop) begin
            slot = blk; sval = 1;
          end else begin
            heldblk = blk; held = 1;
          end
        end else if (bus.I_pop) begin
          sval = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge I_clk);
    model_edge();
    @(negedge I_clk);
    chk("valid", 128'(bus.O_data_valid), 128'(sval));
    chk("ready", 128'(bus.O_ready), 128'(!held));
    chk("level", 128'(bus.O_level), held ? 128'd0 : 128'(fillq.size()));
    chk("q", dut_q(), slot);
  endtask

  task automatic drive(input bit en, input bit v, input logic [15:0] d,
                       input bit fl, input bit pp, input bit r);
    bus.I_en = en; bus.I_data_valid = v; bus.I_d = d;
    bus.I_flush = fl; bus.I_pop = pp; I_rst = r;
    step();
  endtask

  initial begin
    bus.I_en = 1; bus.I_data_valid = 0; bus.I_d = '0;
    bus.I_flush = 0; bus.I_pop = 0; I_rst = 1;
    held = 0; sval = 0; slot = '0; heldblk = '0;
    // reset
    drive(0, 1, 16'hFFFF, 0, 0, 1);
    chk("rst_q", dut_q(), 128'd0);
    // 1: eight samples back-to-back with pop held high
    for (int i = 1; i <= 8; i++) drive(1, 1, 16'(i), 0, 1, 0);
    chk("t1_q", dut_q(), 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("t1_v", 128'(bus.O_data_valid), 128'd1);
    drive(1, 0, 0, 0, 1, 0);
    chk("t1_pop", 128'(bus.O_data_valid), 128'd0);
    // 2: sixteen samples without pop, then one pop
    for (int i = 0; i < 16; i++) drive(1, 1, 16'(16'h10 + i), 0, 0, 0);
    chk("t2_rdy", 128'(bus.O_ready), 128'd0);
    drive(1, 0, 0, 0, 1, 0);
    chk("t2_q", dut_q(), 128'h001F_001E_001D_001C_001B_001A_0019_0018);
    chk("t2_rdy2", 128'(bus.O_ready), 128'd1);
    drive(1, 0, 0, 0, 1, 0);
    // 3: partial block closed by flush, then flush when empty
    drive(1, 1, 16'hA, 0, 0, 0);
    drive(1, 1, 16'hB, 0, 0, 0);
    drive(1, 1, 16'hC, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    chk("t3_q", dut_q(), 128'h000C_000B_000A);
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 0);
    // 4: enable dropped mid-block
    for (int i = 0; i < 3; i++) drive(1, 1, 16'(16'h40 + i), 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 16'hDEAD, 1, 1, 0);
    chk("t4_lvl", 128'(bus.O_level), 128'd3);
    for (int i = 3; i < 8; i++) drive(1, 1, 16'(16'h40 + i), 0, 0, 0);
    chk("t4_q", dut_q(), 128'h0047_0046_0045_0044_0043_0042_0041_0040);
    // 5: reset with slot full and partial block
    for (int i = 0; i < 5; i++) drive(1, 1, 16'(16'h50 + i), 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);
    chk("t5_q", dut_q(), 128'd0);
    for (int i = 0; i < 8; i++) drive(1, 1, 16'(16'h60 + i), 0, 0, 0);
    // 6: block held, pop coincides with new sample
    for (int i = 0; i < 8; i++) drive(1, 1, 16'(16'h70 + i), 0, 0, 0);
    drive(1, 1, 16'h0BAD, 0, 1, 0);
    drive(1, 1, 16'h0080, 0, 0, 0);
    chk("t6_lvl", 128'(bus.O_level), 128'd1);
    // random traffic
    for (int n = 0; n < 3000; n++)
      drive(($urandom % 8) != 0, ($urandom % 4) != 0, 16'($urandom),
            ($urandom % 12) == 0, ($urandom % 3) == 0, ($urandom % 250) == 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
